main_mem_port_arb: RTL and testbench

Downstream companion of `main_mem_fu`: terminates its two main-memory request channels (channel 1 / channel 2) and serialises them onto a single-ported main-memory interface. It handles one transaction at a time, with round-robin arbitration between channels and request/grant/response handshaking toward memory. It returns read data and one-cycle read/write acks to the functional unit.

---
 rtl/main_mem_pkg.sv | 22 ++
 rtl/main_mem_rr_arb.sv | 41 ++++
 rtl/main_mem_port_arb.sv | 157 +++++++++++++++
 tb/tb_main_mem_port_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared types for the main-memory port arbiter and its round-robin helper.
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        ACK      = 2'd3
    } mm_arb_state_t;

    // Channel select: bit value doubles as the index into per-channel vectors.
    typedef enum logic {
        MM_CH1 = 1'b0,
        MM_CH2 = 1'b1
    } mm_ch_t;

    typedef enum logic {
        MM_READ  = 1'b0,
        MM_WRITE = 1'b1
    } mm_op_t;

endpackage

// File: rtl/main_mem_rr_arb.sv
// Two-way round-robin arbiter: favours the channel not granted last on a tie.
module main_mem_rr_arb
    import main_mem_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  mm_ch_t     adv_ch_i,
    output logic       gnt_valid_o,
    output mm_ch_t     gnt_o,
    output logic [1:0] gnt_oh_o
);

    mm_ch_t last_q;

    // Grant selection from the request vector and the last-granted pointer.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_o       = MM_CH1;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == MM_CH1) ? MM_CH2 : MM_CH1;
        end else if (req_i[1]) begin
            gnt_o = MM_CH2;
        end
        gnt_oh_o = 2'b00;
        if (gnt_valid_o) begin
            gnt_oh_o = (gnt_o == MM_CH2) ? 2'b10 : 2'b01;
        end
    end

    // Pointer resets to channel 2 so channel 1 wins the first tie.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= MM_CH2;
        end else if (advance_i) begin
            last_q <= adv_ch_i;
        end
    end

endmodule

// File: rtl/main_mem_port_arb.sv
// Serialises two functional-unit memory channels onto one request/grant/response port.
module main_mem_port_arb
    import main_mem_pkg::*;
#(
    parameter int unsigned data_width = 32,
    parameter int unsigned addr_size  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [addr_size-1:0]  addr1_i,
    input  logic [addr_size-1:0]  addr2_i,
    input  logic                  read_en1_i,
    input  logic                  read_en2_i,
    input  logic                  write_en1_i,
    input  logic                  write_en2_i,
    input  logic [data_width-1:0] w_data1_i,
    input  logic [data_width-1:0] w_data2_i,
    output logic [data_width-1:0] r_data1_o,
    output logic [data_width-1:0] r_data2_o,
    output logic                  read_ack1_o,
    output logic                  read_ack2_o,
    output logic                  write_ack1_o,
    output logic                  write_ack2_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [addr_size-1:0]  mem_addr_o,
    output logic [data_width-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rsp_valid_i,
    input  logic [data_width-1:0] mem_rdata_i,
    output logic                  protocol_err_o
);

    mm_arb_state_t         state_q, state_d;
    mm_ch_t                sel_q, sel_d;
    mm_op_t                op_q, op_d;
    logic [addr_size-1:0]  addr_q, addr_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic [data_width-1:0] rdata1_q, rdata1_d;
    logic [data_width-1:0] rdata2_q, rdata2_d;
    logic [1:0]            done_q, done_d;

    logic [1:0] rd_en, wr_en, any_en, eligible;
    logic       arb_valid, arb_advance;
    mm_ch_t     arb_gnt;
    logic [1:0] arb_gnt_oh;

    assign rd_en    = {read_en2_i, read_en1_i};
    assign wr_en    = {write_en2_i, write_en1_i};
    assign any_en   = rd_en | wr_en;
    // A channel already served keeps its done flag until it drops both enables.
    assign eligible = any_en & ~done_q;

    main_mem_rr_arb u_rr_arb (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_i       (eligible),
        .advance_i   (arb_advance),
        .adv_ch_i    (sel_q),
        .gnt_valid_o (arb_valid),
        .gnt_o       (arb_gnt),
        .gnt_oh_o    (arb_gnt_oh)
    );

    // Next-state, request latching, read-data capture and done-flag bookkeeping.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata1_d       = rdata1_q;
        rdata2_d       = rdata2_q;
        done_d         = done_q & any_en;
        arb_advance    = 1'b0;
        protocol_err_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    sel_d   = arb_gnt;
                    // Write wins when both enables are set on the picked channel.
                    op_d    = (|(arb_gnt_oh & wr_en)) ? MM_WRITE : MM_READ;
                    addr_d  = (arb_gnt == MM_CH2) ? addr2_i : addr1_i;
                    wdata_d = (arb_gnt == MM_CH2) ? w_data2_i : w_data1_i;
                    protocol_err_o = |(arb_gnt_oh & rd_en & wr_en);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt_i) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    state_d = ACK;
                    if (op_q == MM_READ) begin
                        if (sel_q == MM_CH2) begin
                            rdata2_d = mem_rdata_i;
                        end else begin
                            rdata1_d = mem_rdata_i;
                        end
                    end
                end
            end
            ACK: begin
                // Only mark done if the requester is still holding its enable.
                if (sel_q == MM_CH2) begin
                    done_d[1] = any_en[1];
                end else begin
                    done_d[0] = any_en[0];
                end
                arb_advance = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            sel_q    <= MM_CH1;
            op_q     <= MM_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            done_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            done_q   <= done_d;
        end
    end

    // Memory-side and ack outputs, all zero outside their owning state.
    always_comb begin
        mem_req_o    = (state_q == ISSUE);
        mem_we_o     = mem_req_o && (op_q == MM_WRITE);
        mem_addr_o   = mem_req_o ? addr_q : '0;
        mem_wdata_o  = mem_req_o ? wdata_q : '0;
        read_ack1_o  = (state_q == ACK) && (sel_q == MM_CH1) && (op_q == MM_READ);
        read_ack2_o  = (state_q == ACK) && (sel_q == MM_CH2) && (op_q == MM_READ);
        write_ack1_o = (state_q == ACK) && (sel_q == MM_CH1) && (op_q == MM_WRITE);
        write_ack2_o = (state_q == ACK) && (sel_q == MM_CH2) && (op_q == MM_WRITE);
        r_data1_o    = rdata1_q;
        r_data2_o    = rdata2_q;
    end

endmodule

// File: tb/tb_main_mem_port_arb.sv
// Scoreboard bench: stimulus pushes expected memory requests and acks, a monitor pops and checks.
module tb_main_mem_port_arb;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] addr1_i, addr2_i;
    logic        read_en1_i, read_en2_i, write_en1_i, write_en2_i;
    logic [31:0] w_data1_i, w_data2_i;
    logic [31:0] r_data1_o, r_data2_o;
    logic        read_ack1_o, read_ack2_o, write_ack1_o, write_ack2_o;
    logic        mem_req_o, mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rsp_valid_i;
    logic [31:0] mem_rdata_i;
    logic        protocol_err_o;

    main_mem_port_arb dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .addr1_i         (addr1_i),
        .addr2_i         (addr2_i),
        .read_en1_i      (read_en1_i),
        .read_en2_i      (read_en2_i),
        .write_en1_i     (write_en1_i),
        .write_en2_i     (write_en2_i),
        .w_data1_i       (w_data1_i),
        .w_data2_i       (w_data2_i),
        .r_data1_o       (r_data1_o),
        .r_data2_o       (r_data2_o),
        .read_ack1_o     (read_ack1_o),
        .read_ack2_o     (read_ack2_o),
        .write_ack1_o    (write_ack1_o),
        .write_ack2_o    (write_ack2_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rdata_i     (mem_rdata_i),
        .protocol_err_o  (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        int          ch;
        bit          we;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    mreq_t       mq[$];
    ack_t        aq[$];
    logic [31:0] rdq[$];

    int n_chk  = 0;
    int n_pass = 0;
    int err_cnt = 0;
    int err_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic mreq_t mk_req(input bit we, input logic [15:0] a, input logic [31:0] d);
        mreq_t r;
        r.we = we; r.addr = a; r.wdata = d;
        return r;
    endfunction

    function automatic ack_t mk_ack(input int ch, input bit we, input logic [31:0] d, input int c);
        ack_t a;
        a.ch = ch; a.we = we; a.rdata = d; a.cyc = c;
        return a;
    endfunction

    // Memory responder: grants after gnt_delay cycles of request, responds rsp_delay cycles later.
    bit resp_en   = 1'b1;
    int gnt_delay = 0;
    int rsp_delay = 0;
    int wcnt      = 0;
    bit pend      = 1'b0;

    initial begin
        mem_gnt_i       = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
        forever begin
            @(negedge clk_i);
            if (resp_en) begin
                mem_gnt_i       = 1'b0;
                mem_rsp_valid_i = 1'b0;
                if (reset_i) begin
                    pend = 1'b0;
                    wcnt = 0;
                end else if (pend) begin
                    if (wcnt >= rsp_delay) begin
                        mem_rsp_valid_i = 1'b1;
                        mem_rdata_i     = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
                        pend = 1'b0;
                        wcnt = 0;
                    end else wcnt++;
                end else if (mem_req_o) begin
                    if (wcnt >= gnt_delay) begin
                        mem_gnt_i = 1'b1;
                        pend = 1'b1;
                        wcnt = 0;
                    end else wcnt++;
                end else wcnt = 0;
            end
        end
    end

    task automatic chk_ack(input int ch, input logic rd, input logic wr, input logic [31:0] rdv);
        ack_t e;
        chk("ack_expected", aq.size() > 0, 1'b1);
        chk("ack_single_kind", rd & wr, 1'b0);
        if (aq.size() > 0) begin
            e = aq.pop_front();
            chk("ack_channel", ch, e.ch);
            chk("ack_is_write", wr, e.we);
            chk("ack_cycle", cyc, e.cyc);
            if (!e.we) chk("ack_rdata", rdv, e.rdata);
        end
    endtask

    // Monitor: checks every memory request cycle and every ack pulse against the queues.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (!reset_i) begin
                if (mem_req_o) begin
                    chk("req_expected", mq.size() > 0, 1'b1);
                    if (mq.size() > 0) begin
                        chk("req_we", mem_we_o, mq[0].we);
                        chk("req_addr", mem_addr_o, mq[0].addr);
                        if (mq[0].we) chk("req_wdata", mem_wdata_o, mq[0].wdata);
                        if (mem_gnt_i) void'(mq.pop_front());
                    end
                end
                if (read_ack1_o || write_ack1_o) chk_ack(1, read_ack1_o, write_ack1_o, r_data1_o);
                if (read_ack2_o || write_ack2_o) chk_ack(2, read_ack2_o, write_ack2_o, r_data2_o);
                if (protocol_err_o) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (aq.size() == 0 && mq.size() == 0) break;
            step();
        end
        chk("drain_outstanding", aq.size() + mq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int t0, t1, err_base;

    initial begin
        reset_i = 1'b1;
        addr1_i = '0; addr2_i = '0;
        read_en1_i = 0; read_en2_i = 0; write_en1_i = 0; write_en2_i = 0;
        w_data1_i = '0; w_data2_i = '0;
        step();
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_acks", {read_ack1_o, read_ack2_o, write_ack1_o, write_ack2_o}, 4'b0);
        chk("rst_rdata1", r_data1_o, 32'h0);
        chk("rst_rdata2", r_data2_o, 32'h0);
        chk("rst_perr", protocol_err_o, 1'b0);
        reset_i = 1'b0;
        step();

        // Contention: both channels write in the same cycle, ch1 first, ch2 four cycles later.
        t0 = cyc;
        rdq.push_back(32'h0); rdq.push_back(32'h0);
        mq.push_back(mk_req(1, 16'h1000, 32'hAABBCCDD));
        mq.push_back(mk_req(1, 16'h1004, 32'hEEFF1122));
        aq.push_back(mk_ack(1, 1, 32'h0, t0 + 3));
        aq.push_back(mk_ack(2, 1, 32'h0, t0 + 7));
        addr1_i = 16'h1000; w_data1_i = 32'hAABBCCDD; write_en1_i = 1;
        addr2_i = 16'h1004; w_data2_i = 32'hEEFF1122; write_en2_i = 1;
        drain(40);
        write_en1_i = 0; write_en2_i = 0;
        step();

        // Single read on ch1 with minimum memory latency.
        t0 = cyc;
        rdq.push_back(32'h11223344);
        mq.push_back(mk_req(0, 16'h2000, 32'h0));
        aq.push_back(mk_ack(1, 0, 32'h11223344, t0 + 3));
        addr1_i = 16'h2000; read_en1_i = 1;
        drain(40);
        read_en1_i = 0;
        step();
        chk("rdata1_held", r_data1_o, 32'h11223344);
        chk("rdata2_idle", r_data2_o, 32'h0);

        // Held enable: one service for 20 held cycles, a second after a one-cycle drop.
        t0 = cyc;
        rdq.push_back(32'h0BADF00D);
        mq.push_back(mk_req(0, 16'h0300, 32'h0));
        aq.push_back(mk_ack(1, 0, 32'h0BADF00D, t0 + 3));
        addr1_i = 16'h0300; read_en1_i = 1;
        repeat (20) step();
        chk("held_first_done", aq.size() + mq.size(), 0);
        read_en1_i = 0;
        step();
        t1 = cyc;
        rdq.push_back(32'h0BADF00E);
        mq.push_back(mk_req(0, 16'h0300, 32'h0));
        aq.push_back(mk_ack(1, 0, 32'h0BADF00E, t1 + 3));
        read_en1_i = 1;
        drain(40);
        read_en1_i = 0;
        step();

        // Backpressure: grant 5 cycles after request, response 3 cycles after grant.
        gnt_delay = 5; rsp_delay = 2;
        t0 = cyc;
        rdq.push_back(32'hCAFEF00D);
        mq.push_back(mk_req(0, 16'h0ABC, 32'h0));
        aq.push_back(mk_ack(1, 0, 32'hCAFEF00D, t0 + 10));
        addr1_i = 16'h0ABC; read_en1_i = 1;
        drain(60);
        read_en1_i = 0; gnt_delay = 0; rsp_delay = 0;
        step();

        // Illegal read+write on ch2: serviced as a write, one protocol error pulse.
        err_base = err_cnt;
        t0 = cyc;
        rdq.push_back(32'h0);
        mq.push_back(mk_req(1, 16'h0040, 32'h5));
        aq.push_back(mk_ack(2, 1, 32'h0, t0 + 3));
        addr2_i = 16'h0040; w_data2_i = 32'h5; read_en2_i = 1; write_en2_i = 1;
        drain(40);
        chk("perr_count", err_cnt - err_base, 1);
        chk("perr_cycle", err_cyc, t0);
        read_en2_i = 0; write_en2_i = 0;
        step();

        // Reset while waiting for the response, then a stale response.
        rsp_delay = 50;
        t0 = cyc;
        mq.push_back(mk_req(0, 16'h0999, 32'h0));
        addr1_i = 16'h0999; read_en1_i = 1;
        step();
        step();
        #2;
        reset_i = 1'b1;
        #1;
        chk("midrst_mem_req", mem_req_o, 1'b0);
        chk("midrst_mem_addr", mem_addr_o, 16'h0);
        chk("midrst_acks", {read_ack1_o, read_ack2_o, write_ack1_o, write_ack2_o}, 4'b0);
        chk("midrst_rdata1", r_data1_o, 32'h0);
        chk("midrst_rdata2", r_data2_o, 32'h0);
        read_en1_i = 0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        rsp_delay = 0;
        resp_en = 1'b0;
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b0;
        resp_en = 1'b1;
        repeat (3) step();
        chk("stale_rdata1", r_data1_o, 32'h0);
        chk("stale_mem_req", mem_req_o, 1'b0);
        chk("stale_no_pending", aq.size() + mq.size(), 0);

        // After reset the pointer favours ch1 again on a read tie.
        t0 = cyc;
        rdq.push_back(32'hA1A1A1A1); rdq.push_back(32'hB2B2B2B2);
        mq.push_back(mk_req(0, 16'h0010, 32'h0));
        mq.push_back(mk_req(0, 16'h0020, 32'h0));
        aq.push_back(mk_ack(1, 0, 32'hA1A1A1A1, t0 + 3));
        aq.push_back(mk_ack(2, 0, 32'hB2B2B2B2, t0 + 7));
        addr1_i = 16'h0010; addr2_i = 16'h0020; read_en1_i = 1; read_en2_i = 1;
        drain(40);
        read_en1_i = 0; read_en2_i = 0;
        step();
        chk("final_rdata1", r_data1_o, 32'hA1A1A1A1);
        chk("final_rdata2", r_data2_o, 32'hB2B2B2B2);
        chk("perr_total", err_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
